// File: rtl/conv_seq_ctrl.sv
// Convolution tap sequencer: walks ker_x, ker_y, ch, out_x, out_y (innermost first)
// and emits one tap per accepted handshake, with padding and accumulator framing flags.
module conv_seq_ctrl #(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned K      = 3,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned PAD    = 0,
  parameter int unsigned CH     = 1,
  parameter int unsigned CW     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_ctrl,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic                 busy,
  output logic [CW-1:0]        out_y,
  output logic [CW-1:0]        out_x,
  output logic [CW-1:0]        ch,
  output logic [CW-1:0]        ker_y,
  output logic [CW-1:0]        ker_x,
  output logic signed [CW-1:0] in_row,
  output logic signed [CW-1:0] in_col,
  output logic                 pad,
  output logic                 acc_clr,
  output logic                 acc_last,
  output logic                 finish
);

  localparam int unsigned OUT_W = (IMG_W + 2 * PAD - K) / STRIDE + 1;
  localparam int unsigned OUT_H = (IMG_H + 2 * PAD - K) / STRIDE + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] K_MAX    = CW'(K - 1);
  localparam logic [CW-1:0] CH_MAX   = CW'(CH - 1);
  localparam logic [CW-1:0] OX_MAX   = CW'(OUT_W - 1);
  localparam logic [CW-1:0] OY_MAX   = CW'(OUT_H - 1);
  localparam logic [CW-1:0] STRIDE_C = CW'(STRIDE);
  localparam logic [CW-1:0] PAD_C    = CW'(PAD);
  localparam logic signed [CW-1:0] IMG_W_S = CW'(IMG_W);
  localparam logic signed [CW-1:0] IMG_H_S = CW'(IMG_H);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] kx_q, kx_d;
  logic [CW-1:0] ky_q, ky_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [CW-1:0] ox_q, ox_d;
  logic [CW-1:0] oy_q, oy_d;
  logic [CW-1:0] row_u, col_u;

  // State and loop counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      kx_q    <= '0;
      ky_q    <= '0;
      ch_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
    end else begin
      state_q <= state_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      ch_q    <= ch_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
    end
  end

  // Next state and nested counter carry chain; counters move only on accept
  always_comb begin
    state_d = state_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ch_d    = ch_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    case (state_q)
      S_IDLE: begin
        if (en_ctrl) begin
          state_d = S_RUN;
          kx_d    = '0;
          ky_d    = '0;
          ch_d    = '0;
          ox_d    = '0;
          oy_d    = '0;
        end
      end
      S_RUN: begin
        if (out_ready) begin
          kx_d = kx_q + CW'(1);
          if (kx_q == K_MAX) begin
            kx_d = '0;
            ky_d = ky_q + CW'(1);
            if (ky_q == K_MAX) begin
              ky_d = '0;
              ch_d = ch_q + CW'(1);
              if (ch_q == CH_MAX) begin
                ch_d = '0;
                ox_d = ox_q + CW'(1);
                if (ox_q == OX_MAX) begin
                  ox_d = '0;
                  oy_d = oy_q + CW'(1);
                  if (oy_q == OY_MAX) begin
                    oy_d    = '0;
                    state_d = S_DONE;
                  end
                end
              end
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign out_valid = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN);
  assign finish    = (state_q == S_DONE);

  assign out_y = oy_q;
  assign out_x = ox_q;
  assign ch    = ch_q;
  assign ker_y = ky_q;
  assign ker_x = kx_q;

  // Input coordinate wraps modulo 2^CW, so the border subtraction yields a signed result
  assign row_u  = oy_q * STRIDE_C + ky_q - PAD_C;
  assign col_u  = ox_q * STRIDE_C + kx_q - PAD_C;
  assign in_row = $signed(row_u);
  assign in_col = $signed(col_u);

  assign pad = in_row[CW-1] || (in_row >= IMG_H_S) || in_col[CW-1] || (in_col >= IMG_W_S);

  assign acc_clr  = out_valid && (ch_q == '0) && (ky_q == '0) && (kx_q == '0);
  assign acc_last = out_valid && (ch_q == CH_MAX) && (ky_q == K_MAX) && (kx_q == K_MAX);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: four parameterisations driven one at a time, every tap
// compared against a loop-nest model of the expected coordinate sequence.
module tb_conv_seq_ctrl;

  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic reset;
  logic en [4];
  logic ready;

  logic                 valid_w  [4];
  logic                 busy_w   [4];
  logic [CW-1:0]        oy_w     [4];
  logic [CW-1:0]        ox_w     [4];
  logic [CW-1:0]        ch_w     [4];
  logic [CW-1:0]        ky_w     [4];
  logic [CW-1:0]        kx_w     [4];
  logic signed [CW-1:0] row_w    [4];
  logic signed [CW-1:0] col_w    [4];
  logic                 pad_w    [4];
  logic                 clr_w    [4];
  logic                 last_w   [4];
  logic                 finish_w [4];

  int checks;
  int errors;

  always #5 clk = ~clk;

  // 0: 4x4 K3 S1 P0 CH1; 1: 4x4 P1; 2: 5x5 S2; 3: 4x4 CH2
  conv_seq_ctrl #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .PAD(0), .CH(1), .CW(CW)) u_a (
    .clk(clk), .reset(reset), .en_ctrl(en[0]), .out_ready(ready),
    .out_valid(valid_w[0]), .busy(busy_w[0]), .out_y(oy_w[0]), .out_x(ox_w[0]),
    .ch(ch_w[0]), .ker_y(ky_w[0]), .ker_x(kx_w[0]), .in_row(row_w[0]), .in_col(col_w[0]),
    .pad(pad_w[0]), .acc_clr(clr_w[0]), .acc_last(last_w[0]), .finish(finish_w[0]));

  conv_seq_ctrl #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .PAD(1), .CH(1), .CW(CW)) u_b (
    .clk(clk), .reset(reset), .en_ctrl(en[1]), .out_ready(ready),
    .out_valid(valid_w[1]), .busy(busy_w[1]), .out_y(oy_w[1]), .out_x(ox_w[1]),
    .ch(ch_w[1]), .ker_y(ky_w[1]), .ker_x(kx_w[1]), .in_row(row_w[1]), .in_col(col_w[1]),
    .pad(pad_w[1]), .acc_clr(clr_w[1]), .acc_last(last_w[1]), .finish(finish_w[1]));

  conv_seq_ctrl #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2), .PAD(0), .CH(1), .CW(CW)) u_c (
    .clk(clk), .reset(reset), .en_ctrl(en[2]), .out_ready(ready),
    .out_valid(valid_w[2]), .busy(busy_w[2]), .out_y(oy_w[2]), .out_x(ox_w[2]),
    .ch(ch_w[2]), .ker_y(ky_w[2]), .ker_x(kx_w[2]), .in_row(row_w[2]), .in_col(col_w[2]),
    .pad(pad_w[2]), .acc_clr(clr_w[2]), .acc_last(last_w[2]), .finish(finish_w[2]));

  conv_seq_ctrl #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .PAD(0), .CH(2), .CW(CW)) u_d (
    .clk(clk), .reset(reset), .en_ctrl(en[3]), .out_ready(ready),
    .out_valid(valid_w[3]), .busy(busy_w[3]), .out_y(oy_w[3]), .out_x(ox_w[3]),
    .ch(ch_w[3]), .ker_y(ky_w[3]), .ker_x(kx_w[3]), .in_row(row_w[3]), .in_col(col_w[3]),
    .pad(pad_w[3]), .acc_clr(clr_w[3]), .acc_last(last_w[3]), .finish(finish_w[3]));

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected tap t of the loop nest ker_x, ker_y, ch, out_x, out_y
  task automatic chk_tap(input int s, input int t, input int k, input int st, input int p,
                         input int nch, input int ow, input int iw, input int ih);
    int kx, ky, c, ox, oy, ir, ic;
    kx = t % k;
    ky = (t / k) % k;
    c  = (t / (k * k)) % nch;
    ox = (t / (k * k * nch)) % ow;
    oy = t / (k * k * nch * ow);
    ir = oy * st + ky - p;
    ic = ox * st + kx - p;
    chk("ker_x", kx_w[s], kx);
    chk("ker_y", ky_w[s], ky);
    chk("ch", ch_w[s], c);
    chk("out_x", ox_w[s], ox);
    chk("out_y", oy_w[s], oy);
    chk("in_row", row_w[s], ir);
    chk("in_col", col_w[s], ic);
    chk("pad", pad_w[s], (ir < 0 || ir >= ih || ic < 0 || ic >= iw) ? 1 : 0);
    chk("acc_clr", clr_w[s], (c == 0 && ky == 0 && kx == 0) ? 1 : 0);
    chk("acc_last", last_w[s], (c == nch - 1 && ky == k - 1 && kx == k - 1) ? 1 : 0);
  endtask

  task automatic chk_idle(input int s);
    chk("idle_valid", valid_w[s], 0);
    chk("idle_busy", busy_w[s], 0);
    chk("idle_finish", finish_w[s], 0);
    chk("idle_acc_clr", clr_w[s], 0);
    chk("idle_acc_last", last_w[s], 0);
    chk("idle_ker_x", kx_w[s], 0);
    chk("idle_ker_y", ky_w[s], 0);
    chk("idle_ch", ch_w[s], 0);
    chk("idle_out_x", ox_w[s], 0);
    chk("idle_out_y", oy_w[s], 0);
  endtask

  // One run: pulse en, observe every cycle on the falling edge, optional stall or reset
  task automatic run(input int s, input int k, input int st, input int p, input int nch,
                     input int iw, input int ih, input int stall_at, input int stall_len,
                     input int rst_at);
    int ow, oh, total, acc, post, cyc, stall, finish_cyc;
    bit done;
    ow = (iw + 2 * p - k) / st + 1;
    oh = (ih + 2 * p - k) / st + 1;
    total = oh * ow * nch * k * k;
    acc = 0; post = 0; cyc = 0; stall = 0; finish_cyc = -1; done = 1'b0;
    @(negedge clk);
    en[s] = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    en[s] = 1'b0;
    cyc = 1;
    while (!done && cyc < 1000) begin
      if (acc < total) begin
        chk("valid", valid_w[s], 1);
        chk("busy", busy_w[s], 1);
        chk("finish_run", finish_w[s], 0);
        chk_tap(s, acc, k, st, p, nch, ow, iw, ih);
        if (acc == rst_at) begin
          reset = 1'b0;
          #1;
          chk_idle(s);
          repeat (2) begin
            @(negedge clk);
            chk("rst_finish", finish_w[s], 0);
            chk("rst_valid", valid_w[s], 0);
          end
          reset = 1'b1;
          @(negedge clk);
          chk_idle(s);
          done = 1'b1;
        end else if (acc == stall_at && stall < stall_len) begin
          ready = 1'b0;
          stall++;
        end else begin
          ready = 1'b1;
          acc++;
        end
      end else begin
        ready = 1'b1;
        post++;
        chk("valid_end", valid_w[s], 0);
        chk("busy_end", busy_w[s], 0);
        chk("finish_end", finish_w[s], (post == 1) ? 1 : 0);
        if (post == 1) finish_cyc = cyc;
        if (post == 2) done = 1'b1;
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    ready = 1'b1;
    if (!done) chk("timeout", 0, 1);
    else if (rst_at < 0) begin
      chk("taps", acc, total);
      chk("finish_cycle", finish_cyc, total + 1 + stall_len);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    ready  = 1'b1;
    for (int i = 0; i < 4; i++) en[i] = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) chk_idle(i);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle(0);

    run(0, 3, 1, 0, 1, 4, 4, -1, 0, -1);
    run(1, 3, 1, 1, 1, 4, 4, -1, 0, -1);
    run(2, 3, 2, 0, 1, 5, 5, -1, 0, -1);
    run(3, 3, 1, 0, 2, 4, 4, -1, 0, -1);
    run(0, 3, 1, 0, 1, 4, 4, 5, 3, -1);
    run(0, 3, 1, 0, 1, 4, 4, -1, 0, 10);
    run(0, 3, 1, 0, 1, 4, 4, -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
